// File: rtl/clock_pkg.sv
// Shared types and constants for the BCD day-of-month entry block.
package clock_pkg;

  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned BIN_W          = 6;
  localparam int unsigned DAY_MIN        = 1;
  localparam int unsigned DAY_MAX        = 31;
  localparam int unsigned MONTH_MIN_DAYS = 28;
  localparam int unsigned TENS_MAX       = 3;
  localparam int unsigned ONES_MAX       = 9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ONES = 2'd1,
    ST_CHECK     = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_pair_t;

  // A month length outside 28..31 is not trustworthy, so fall back to 31.
  function automatic logic [BIN_W-1:0] eff_max_day(input logic [BIN_W-1:0] max_day);
    if (max_day >= BIN_W'(MONTH_MIN_DAYS) && max_day <= BIN_W'(DAY_MAX)) begin
      return max_day;
    end
    return BIN_W'(DAY_MAX);
  endfunction

endpackage

// File: rtl/bcd_day_entry_if.sv
// Keypad-side and result-side signals of the day entry block.
interface bcd_day_entry_if;
  import clock_pkg::*;

  logic               digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic               abort;
  logic [BIN_W-1:0]   max_day;
  logic [BIN_W-1:0]   bin;
  logic               bin_valid;
  logic               err;
  logic               busy;

  modport master (
    output digit_valid, digit, abort, max_day,
    input  bin, bin_valid, err, busy
  );

  modport slave (
    input  digit_valid, digit, abort, max_day,
    output bin, bin_valid, err, busy
  );

endinterface

// File: rtl/bcd_pair_to_bin.sv
// Two BCD digits to binary using tens*10 = (tens<<3)+(tens<<1).
module bcd_pair_to_bin
  import clock_pkg::*;
(
  input  logic [DIGIT_W-1:0] tens,
  input  logic [DIGIT_W-1:0] ones,
  output logic [BIN_W-1:0]   bin
);

  logic [BIN_W-1:0] tens_w;
  logic [BIN_W-1:0] ones_w;

  always_comb begin
    tens_w = BIN_W'(tens);
    ones_w = BIN_W'(ones);
    bin    = (tens_w << 3) + (tens_w << 1) + ones_w;
  end

endmodule

// File: rtl/bcd_day_entry.sv
// Two-keypress BCD day entry with range check against the month length and an inter-digit timeout.
module bcd_day_entry
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
)
(
  input  logic           clk,
  input  logic           rst,
  bcd_day_entry_if.slave bus
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  bcd_pair_t        pair_q, pair_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             bin_valid_q, bin_valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [BIN_W-1:0] value_c;
  logic [BIN_W-1:0] limit_c;
  logic             value_ok_c;

  bcd_pair_to_bin u_pair_to_bin (
    .tens (pair_q.tens),
    .ones (pair_q.ones),
    .bin  (value_c)
  );

  always_comb begin
    limit_c    = eff_max_day(bus.max_day);
    value_ok_c = (value_c >= BIN_W'(DAY_MIN)) && (value_c <= limit_c);
  end

  // Next-state and output decode; abort outranks any digit or timeout.
  always_comb begin
    state_d     = state_q;
    pair_d      = pair_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bus.abort && bus.digit_valid) begin
          if (bus.digit <= DIGIT_W'(TENS_MAX)) begin
            pair_d.tens = bus.digit;
            cnt_d       = '0;
            state_d     = ST_WAIT_ONES;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_WAIT_ONES: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.digit_valid) begin
          if (bus.digit <= DIGIT_W'(ONES_MAX)) begin
            pair_d.ones = bus.digit;
            state_d     = ST_CHECK;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CHECK: begin
        state_d = ST_IDLE;
        if (!bus.abort) begin
          if (value_ok_c) begin
            bin_d       = value_c;
            bin_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pair_q      <= '0;
      cnt_q       <= '0;
      bin_q       <= BIN_W'(DAY_MIN);
      bin_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pair_q      <= pair_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.bin       = bin_q;
  assign bus.bin_valid = bin_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bcd_day_entry.sv
// Bench for bcd_day_entry: directed table, hand sequences around the timeout, and random traffic vs a keystroke model.
module tb_bcd_day_entry;
  import clock_pkg::*;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_day_entry_if bus();

  bcd_day_entry #(.TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit    r;
    bit    dv;
    int    d;
    bit    ab;
    int    md;
    int    e_bin;
    bit    e_bv;
    bit    e_err;
    bit    e_busy;
    string name;
  } vec_t;

  vec_t tbl[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  // Keystroke-level reference: digits of the open entry, idle cycles since the tens digit.
  int m_keys[$];
  bit m_check = 1'b0;
  int m_wait  = 0;
  int m_bin   = 1;
  bit m_bv    = 1'b0;
  bit m_err   = 1'b0;

  function automatic bit m_busy();
    return m_check || (m_keys.size() > 0);
  endfunction

  task automatic model_step(bit r, bit dv, int d, bit ab, int md);
    int v;
    int lim;
    m_bv  = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_keys.delete();
      m_check = 1'b0;
      m_wait  = 0;
      m_bin   = 1;
    end else if (ab) begin
      m_keys.delete();
      m_check = 1'b0;
    end else if (m_check) begin
      v   = m_keys[0] * 10 + m_keys[1];
      lim = (md >= 28 && md <= 31) ? md : 31;
      if (v >= 1 && v <= lim) begin
        m_bin = v;
        m_bv  = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      m_keys.delete();
      m_check = 1'b0;
    end else if (m_keys.size() == 0) begin
      if (dv) begin
        if (d <= 3) begin
          m_keys.push_back(d);
          m_wait = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else begin
      if (dv) begin
        if (d <= 9) begin
          m_keys.push_back(d);
          m_check = 1'b1;
        end else begin
          m_err = 1'b1;
          m_keys.delete();
        end
      end else begin
        m_wait++;
        if (m_wait >= TO) begin
          m_err = 1'b1;
          m_keys.delete();
        end
      end
    end
  endtask

  task automatic tick(bit r, bit dv, int d, bit ab, int md);
    rst             = r;
    bus.digit_valid = dv;
    bus.digit       = 4'(d);
    bus.abort       = ab;
    bus.max_day     = 6'(md);
    @(posedge clk);
    model_step(r, dv, d, ab, md);
    #1;
  endtask

  task automatic check(string name, int e_bin, bit e_bv, bit e_err, bit e_busy);
    vec_cnt++;
    if (bus.bin !== 6'(e_bin) || bus.bin_valid !== e_bv || bus.err !== e_err ||
        bus.busy !== e_busy || (bus.bin_valid && bus.err)) begin
      miss_cnt++;
      $display("FAIL %s @%0t: got bin=%0d bin_valid=%0b err=%0b busy=%0b, want bin=%0d bin_valid=%0b err=%0b busy=%0b",
               name, $time, bus.bin, bus.bin_valid, bus.err, bus.busy, e_bin, e_bv, e_err, e_busy);
    end
  endtask

  task automatic add(string n, bit r, bit dv, int d, bit ab, int md,
                     int eb, bit ebv, bit eerr, bit ebusy);
    vec_t v;
    v.r = r; v.dv = dv; v.d = d; v.ab = ab; v.md = md;
    v.e_bin = eb; v.e_bv = ebv; v.e_err = eerr; v.e_busy = ebusy; v.name = n;
    tbl.push_back(v);
  endtask

  initial begin
    int dv_pct;
    int d;
    int md;
    bit r;
    bit ab;
    bit dv;

    rst             = 1'b1;
    bus.digit_valid = 1'b0;
    bus.digit       = '0;
    bus.abort       = 1'b0;
    bus.max_day     = 6'd31;

    //   name            rst dv d  ab md  | bin bv err busy
    add("reset",          1, 0, 0, 0, 31,   1, 0, 0, 0);
    add("d27_tens",       0, 1, 2, 0, 31,   1, 0, 0, 1);
    add("d27_ones",       0, 1, 7, 0, 31,   1, 0, 0, 1);
    add("d27_result",     0, 0, 0, 0, 31,  27, 1, 0, 0);
    add("d31_tens",       0, 1, 3, 0, 30,  27, 0, 0, 1);
    add("d31_ones",       0, 1, 1, 0, 30,  27, 0, 0, 1);
    add("d31_m30_err",    0, 0, 0, 0, 30,  27, 0, 1, 0);
    add("d29_tens",       0, 1, 2, 0, 28,  27, 0, 0, 1);
    add("d29_ones",       0, 1, 9, 0, 28,  27, 0, 0, 1);
    add("d29_m28_err",    0, 0, 0, 0, 28,  27, 0, 1, 0);
    add("d00_tens",       0, 1, 0, 0, 31,  27, 0, 0, 1);
    add("d00_ones",       0, 1, 0, 0, 31,  27, 0, 0, 1);
    add("d00_err",        0, 0, 0, 0, 31,  27, 0, 1, 0);
    add("tens5_err",      0, 1, 5, 0, 31,  27, 0, 1, 0);
    add("tens5_idle",     0, 0, 0, 0, 31,  27, 0, 0, 0);
    add("m45_tens",       0, 1, 3, 0, 45,  27, 0, 0, 1);
    add("m45_ones",       0, 1, 1, 0, 45,  27, 0, 0, 1);
    add("m45_as31",       0, 0, 0, 0, 45,  31, 1, 0, 0);
    add("m0_tens",        0, 1, 3, 0,  0,  31, 0, 0, 1);
    add("m0_ones",        0, 1, 0, 0,  0,  31, 0, 0, 1);
    add("m0_as31",        0, 0, 0, 0,  0,  30, 1, 0, 0);
    add("m29_tens",       0, 1, 2, 0, 29,  30, 0, 0, 1);
    add("m29_ones",       0, 1, 9, 0, 29,  30, 0, 0, 1);
    add("m29_ok",         0, 0, 0, 0, 29,  29, 1, 0, 0);
    add("abw_tens",       0, 1, 1, 0, 31,  29, 0, 0, 1);
    add("abw_abort",      0, 1, 5, 1, 31,  29, 0, 0, 0);
    add("abw_after",      0, 0, 0, 0, 31,  29, 0, 0, 0);
    add("abc_tens",       0, 1, 2, 0, 31,  29, 0, 0, 1);
    add("abc_ones",       0, 1, 5, 0, 31,  29, 0, 0, 1);
    add("abc_abort",      0, 0, 0, 1, 31,  29, 0, 0, 0);
    add("ones12_tens",    0, 1, 1, 0, 31,  29, 0, 0, 1);
    add("ones12_err",     0, 1,12, 0, 31,  29, 0, 1, 0);
    add("chkdig_tens",    0, 1, 1, 0, 31,  29, 0, 0, 1);
    add("chkdig_ones",    0, 1, 2, 0, 31,  29, 0, 0, 1);
    add("chkdig_ignored", 0, 1, 3, 0, 31,  12, 1, 0, 0);
    add("chkdig_idle",    0, 0, 0, 0, 31,  12, 0, 0, 0);
    add("b2b_t1",         0, 1, 1, 0, 31,  12, 0, 0, 1);
    add("b2b_o5",         0, 1, 5, 0, 31,  12, 0, 0, 1);
    add("b2b_r15",        0, 0, 0, 0, 31,  15, 1, 0, 0);
    add("b2b_t0",         0, 1, 0, 0, 31,  15, 0, 0, 1);
    add("b2b_o1",         0, 1, 1, 0, 31,  15, 0, 0, 1);
    add("b2b_r1",         0, 0, 0, 0, 31,   1, 1, 0, 0);
    add("d23_tens",       0, 1, 2, 0, 31,   1, 0, 0, 1);
    add("d23_ones",       0, 1, 3, 0, 31,   1, 0, 0, 1);
    add("d23_result",     0, 0, 0, 0, 31,  23, 1, 0, 0);
    add("rstw_tens",      0, 1, 1, 0, 31,  23, 0, 0, 1);
    add("rstw_rst",       1, 1, 5, 1, 31,   1, 0, 0, 0);
    add("rstw_after",     0, 0, 0, 0, 31,   1, 0, 0, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].dv, tbl[i].d, tbl[i].ab, tbl[i].md);
      check(tbl[i].name, tbl[i].e_bin, tbl[i].e_bv, tbl[i].e_err, tbl[i].e_busy);
    end

    // Timeout: 15 idle cycles keep the entry, the 16th expires it.
    tick(0, 1, 1, 0, 31);
    check("to_tens", 1, 0, 0, 1);
    for (int i = 1; i < int'(TO); i++) begin
      tick(0, 0, 0, 0, 31);
      check("to_wait", 1, 0, 0, 1);
    end
    tick(0, 0, 0, 0, 31);
    check("to_expire", 1, 0, 1, 0);
    tick(0, 1, 9, 0, 31);
    check("to_nine_as_tens", 1, 0, 1, 0);
    tick(0, 0, 0, 0, 31);
    check("to_quiet", 1, 0, 0, 0);

    // A digit arriving on the last allowed cycle still counts.
    tick(0, 1, 1, 0, 31);
    check("edge_tens", 1, 0, 0, 1);
    for (int i = 1; i < int'(TO); i++) begin
      tick(0, 0, 0, 0, 31);
      check("edge_wait", 1, 0, 0, 1);
    end
    tick(0, 1, 4, 0, 31);
    check("edge_ones", 1, 0, 0, 1);
    tick(0, 0, 0, 0, 31);
    check("edge_result", 14, 1, 0, 0);

    // Random traffic against the model, alternating busy and sparse keypress phases.
    tick(1, 0, 0, 0, 31);
    check("rand_reset", m_bin, m_bv, m_err, m_busy());
    dv_pct = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 64 == 0) dv_pct = ($urandom_range(0, 1) == 0) ? 50 : 4;
      r  = ($urandom_range(0, 199) == 0);
      ab = ($urandom_range(0, 19) == 0);
      dv = ($urandom_range(0, 99) < dv_pct);
      d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      md = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(28, 31));
      tick(r, dv, d, ab, md);
      check("rand", m_bin, m_bv, m_err, m_busy());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_day_entry.md
BCD_DAY_ENTRY -- requirements
Module: bcd_day_entry

Interface
REQ-001 Parameter: TIMEOUT_CYC, 50_000_000, max clock cycles allowed between tens and ones digit.
REQ-002 Port: clk  input  1  system clock, rising-edge active.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: digit_valid  input  1  digit strobe, one cycle per keypress.
REQ-005 Port: digit  input  4  BCD digit; qualified by digit_valid.
REQ-006 Port: abort  input  1  cancel current entry.
REQ-007 Port: max_day  input  6  last legal day of the current month, binary.
REQ-008 Port: bin  output  6  last accepted day, binary 1..31.
REQ-009 Port: bin_valid  output  1  one-cycle pulse when bin updates.
REQ-010 Port: err  output  1  one-cycle pulse on rejected or timed-out entry.
REQ-011 Port: busy  output  1  high while an entry is in progress.

Function
REQ-012 Entry order SHALL be tens digit, then ones digit; the module SHALL accept only digits.
REQ-013 The FSM SHALL have states IDLE, WAIT_ONES and CHECK.
REQ-014 IDLE + digit_valid with digit 0..3 SHALL latch the tens digit and go to WAIT_ONES, clearing the timeout counter.
REQ-015 IDLE + digit_valid with digit 4..15 SHALL pulse err on the next cycle and remain in IDLE.
REQ-016 WAIT_ONES + digit_valid with digit 0..9 SHALL latch the ones digit and go to CHECK.
REQ-017 WAIT_ONES + digit_valid with digit 10..15 SHALL pulse err and return to IDLE.
REQ-018 In WAIT_ONES the timeout counter SHALL increment each cycle; a count of TIMEOUT_CYC-1 without a digit SHALL pulse err and return to IDLE.
REQ-019 In CHECK, the value SHALL be computed as tens*10+ones using shift-add ((t<<3)+(t<<1)+o), in 6 bits. No overflow is possible (max 39).
REQ-020 In CHECK, max_day SHALL be sampled; a value outside 28..31 SHALL be treated as 31.
REQ-021 If 1 <= value <= effective max_day, bin SHALL load value and bin_valid SHALL pulse; otherwise err SHALL pulse and bin SHALL hold.
REQ-022 CHECK SHALL always return to IDLE after one cycle.
REQ-023 Latency: bin/bin_valid or err SHALL become visible exactly one clock after the edge that accepts the ones digit.
REQ-024 digit_valid during CHECK SHALL be ignored; no error is raised.
REQ-025 abort SHALL have priority over digit_valid and timeout in every state.
REQ-026 abort SHALL return the FSM to IDLE with no err pulse and no change to bin.
REQ-027 bin_valid and err SHALL never be high in the same cycle.
REQ-028 busy SHALL be high in WAIT_ONES and CHECK, and low in IDLE.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 rst SHALL force IDLE, bin=1, bin_valid=0, err=0, busy=0, and clear the timeout counter and digit latches.
REQ-031 rst asserted mid-entry SHALL discard the partial entry without an err pulse.
REQ-032 rst SHALL override abort and digit_valid in the same cycle.

Structure
REQ-033 State encoding and the constants DAY_MIN=1 and DAY_MAX=31 SHALL live in the shared package clock_pkg.
REQ-034 The tens*10+ones arithmetic SHALL be a combinational sub-module bcd_pair_to_bin (inputs tens[3:0] and ones[3:0], output bin[5:0]).
REQ-035 The timeout counter width SHALL be $clog2(TIMEOUT_CYC).

Verification
REQ-036 Digits 2 then 7, max_day=31 -> bin=27 and bin_valid pulses one cycle after the second digit; err stays 0.
REQ-037 Digits 3 then 1, max_day=30 -> err pulses and bin holds its previous value; digits 2 then 9, max_day=28 -> err pulses.
REQ-038 Digits 0 then 0 -> err pulses (value below 1); a single digit 5 in IDLE -> err pulses and state stays IDLE.
REQ-039 With TIMEOUT_CYC=16: digit 1 then idle for 16 cycles -> err pulses and busy falls; a later digit 9 is treated as a tens digit -> err pulses.
REQ-040 Digit 1, then abort asserted together with digit_valid digit=5 -> returns to IDLE with no err and bin unchanged; rst during WAIT_ONES -> bin=1 and busy=0.
REQ-041 Back-to-back entry (1,5), then (0,1) sent with no gap -> bin=15 then bin=1, with two bin_valid pulses.
